// File: rtl/qcv_pkg.sv
// Shared types and default sizing for the instruction prefetcher.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package qcv_pkg;

    localparam int unsigned QCV_DEPTH           = 3;
    localparam int unsigned QCV_MAX_OUTSTANDING = 2;

    // One buffered fetch result: instruction word, its PC, and bus error flag.
    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        err;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/qcv_fetch_fifo.sv
// Generic synchronous FIFO: push/pop/flush, head data, count, full, empty.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
//
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i empties the
// FIFO (wins over push/pop); push_i/push_dat_i write; pop_i advances the head;
// head_dat_o current head; count_o/full_o/empty_o occupancy.
module qcv_fetch_fifo
    import qcv_pkg::*;
#(
    parameter int unsigned WIDTH = FETCH_ENTRY_W,
    parameter int unsigned DEPTH = QCV_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/qcv_instr_prefetch.sv
// Instruction prefetcher feeding the IF/ID register; flushes and redirects on branch_i.
// Latency: grant in cycle N, rvalid in N+1, valid_o in N+2 (no rvalid->valid_o bypass).
// Backpressure: ready_i low fills the FIFO; requests stop once buffered + in-flight reach DEPTH.
//
// Ports: req_i core enable; branch_i/addr_i redirect; valid_o/ready_i with
// rdata_o/addr_o/err_o head entry; instr_req_o/instr_gnt_i/instr_addr_o issue
// side and instr_rvalid_i/instr_rdata_i/instr_err_i response side of the
// instruction bus; busy_o request pending or response outstanding.
module qcv_instr_prefetch
    import qcv_pkg::*;
#(
    parameter int unsigned DEPTH           = QCV_DEPTH,
    parameter int unsigned MAX_OUTSTANDING = QCV_MAX_OUTSTANDING
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    input  logic        instr_rvalid_i,
    output logic        busy_o
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic             addr_valid_q, addr_valid_d;
    logic             err_stop_q, err_stop_d;
    logic [OUT_W-1:0] discard_q, discard_d;

    fetch_entry_t     fifo_in, fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty, fifo_push;

    logic [31:0]      rsp_pc;
    logic [OUT_W-1:0] outstanding;
    logic             pcq_full, pcq_empty;

    logic             pop, grant, accept_rsp, space_ok;

    // Response buffer; branch_i flushes it and masks any same-cycle push/pop.
    qcv_fetch_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (branch_i),
        .push_i     (fifo_push),
        .push_dat_i (fifo_in),
        .pop_i      (pop),
        .head_dat_o (fifo_head),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // PCs of granted requests, in issue order. Its occupancy is the
    // outstanding count. Never flushed: dropped responses still retire here.
    qcv_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_queue (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .push_i     (grant),
        .push_dat_i (instr_addr_o),
        .pop_i      (instr_rvalid_i),
        .head_dat_o (rsp_pc),
        .count_o    (outstanding),
        .full_o     (pcq_full),
        .empty_o    (pcq_empty)
    );

    assign valid_o = ~fifo_empty & ~branch_i;
    assign rdata_o = fifo_head.rdata;
    assign addr_o  = fifo_head.addr;
    assign err_o   = fifo_head.err;
    assign pop     = valid_o & ready_i;

    // Reserve a FIFO slot for every in-flight request so a response can
    // always be accepted; a same-cycle pop frees one slot early.
    always_comb begin
        space_ok = (int'(fifo_count) - int'(pop) + int'(outstanding)) < int'(DEPTH);
    end

    assign instr_req_o  = req_i & addr_valid_q & ~err_stop_q & ~branch_i
                        & space_ok & ~pcq_full;
    // Low bits of fetch_addr_q are always zero; the mask keeps that explicit.
    assign instr_addr_o = fetch_addr_q & 32'hFFFF_FFFC;
    assign grant        = instr_req_o & instr_gnt_i;
    assign busy_o       = instr_req_o | ~pcq_empty;

    assign accept_rsp = instr_rvalid_i & (discard_q == '0);
    // The issue rule already prevents overflow; the full term only keeps the
    // push consistent with the FIFO's own acceptance.
    assign fifo_push  = accept_rsp & (~fifo_full | pop);

    always_comb begin
        fifo_in       = '0;
        fifo_in.rdata = instr_rdata_i;
        fifo_in.addr  = rsp_pc;
        fifo_in.err   = instr_err_i;
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        addr_valid_d = addr_valid_q;
        err_stop_d   = err_stop_q;
        discard_d    = discard_q;

        if (grant) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
        end
        if (instr_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - OUT_W'(1);
        end
        if (accept_rsp && instr_err_i) begin
            err_stop_d = 1'b1;
        end

        if (branch_i) begin
            fetch_addr_d = addr_i & 32'hFFFF_FFFC;
            addr_valid_d = 1'b1;
            err_stop_d   = 1'b0;
            // Every response still in flight after this cycle belongs to the
            // old stream, including ones already marked for discard.
            discard_d    = outstanding - OUT_W'(instr_rvalid_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q <= '0;
            addr_valid_q <= 1'b0;
            err_stop_q   <= 1'b0;
            discard_q    <= '0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            addr_valid_q <= addr_valid_d;
            err_stop_q   <= err_stop_d;
            discard_q    <= discard_d;
        end
    end

endmodule
